// File: rtl/fd_rate_arbiter.sv
// Round-robin arbiter and sequencer for the shared frequency divider.
// Grants one requester at a time and restarts the divider at its rate.
//
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   req           per-requester level request
//   req_sel       2-bit rate select per requester, [2i+1:2i]
//   hold_periods  divided-clock rising edges per grant, 0 = unlimited
//   clk_after     divided clock returned by the divider
//   fd_reset      divider reset_fd
//   fd_sel        divider sel, ratio 2^(10+fd_sel)
//   gnt           one-hot grant
//   busy          a grant is active
//   tick          one pulse per counted clk_after rising edge
//   done          one pulse when the hold count completes
module fd_rate_arbiter #(
   parameter int NREQ   = 4,
   parameter int HOLD_W = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NREQ-1:0]     req,
   input  logic [2*NREQ-1:0]   req_sel,
   input  logic [HOLD_W-1:0]   hold_periods,
   input  logic                clk_after,
   output logic                fd_reset,
   output logic [1:0]          fd_sel,
   output logic [NREQ-1:0]     gnt,
   output logic                busy,
   output logic                tick,
   output logic                done
);

   localparam int IW = $clog2(NREQ);
   localparam logic [IW:0] NREQ_W = NREQ[IW:0];

   typedef enum logic [1:0] {
      IDLE,
      START,
      RUN
   } state_t;

   state_t              state_q, state_d;
   logic [IW-1:0]       ptr_q, ptr_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [HOLD_W-1:0]   cnt_q, cnt_d;
   logic                prev_q, prev_d;

   logic                fd_reset_d;
   logic [1:0]          fd_sel_d;
   logic [NREQ-1:0]     gnt_d;
   logic                busy_d;
   logic                tick_d;
   logic                done_d;

   logic [NREQ-1:0]     rot;
   logic [IW-1:0]       off;
   logic [IW:0]         sum;
   logic [IW:0]         inc;
   logic [IW-1:0]       pick;
   logic [IW-1:0]       pick_inc;
   logic [1:0]          pick_sel;
   logic [NREQ-1:0]     pick_oh;
   logic                rise;
   logic [HOLD_W-1:0]   cnt_inc;

   // Requests rotated so bit 0 is the pointer position; the lowest
   // set bit of the rotated vector is the round-robin winner.
   always_comb begin
      rot = NREQ'({req, req} >> ptr_q);
      off = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            off = IW'(k);
         end
      end
      sum = {1'b0, ptr_q} + {1'b0, off};
      if (sum >= NREQ_W) begin
         sum = sum - NREQ_W;
      end
      pick = sum[IW-1:0];
      inc = {1'b0, pick} + 1'b1;
      if (inc == NREQ_W) begin
         inc = '0;
      end
      pick_inc = inc[IW-1:0];
      pick_sel = 2'(req_sel >> {pick, 1'b0});
      pick_oh = '0;
      pick_oh[pick] = 1'b1;
   end

   assign rise    = clk_after & ~prev_q;
   assign cnt_inc = cnt_q + 1'b1;

   // Registered outputs are computed for the state being entered, so
   // they change on the same edge as the state.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      idx_d      = idx_q;
      hold_d     = hold_q;
      cnt_d      = cnt_q;
      prev_d     = prev_q;
      fd_reset_d = fd_reset;
      fd_sel_d   = fd_sel;
      gnt_d      = gnt;
      busy_d     = busy;
      tick_d     = 1'b0;
      done_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            fd_reset_d = 1'b1;
            gnt_d      = '0;
            busy_d     = 1'b0;
            if (|req) begin
               idx_d    = pick;
               hold_d   = hold_periods;
               ptr_d    = pick_inc;
               fd_sel_d = pick_sel;
               gnt_d    = pick_oh;
               busy_d   = 1'b1;
               state_d  = START;
            end
         end
         START: begin
            cnt_d      = '0;
            prev_d     = 1'b0;
            fd_reset_d = 1'b0;
            state_d    = RUN;
         end
         RUN: begin
            prev_d = clk_after;
            if (!req[idx_q]) begin
               // Abort wins over a coincident edge or completion.
               fd_reset_d = 1'b1;
               gnt_d      = '0;
               busy_d     = 1'b0;
               state_d    = IDLE;
            end else if (rise) begin
               tick_d = 1'b1;
               cnt_d  = cnt_inc;
               if (hold_q != '0 && cnt_inc == hold_q) begin
                  done_d     = 1'b1;
                  fd_reset_d = 1'b1;
                  gnt_d      = '0;
                  busy_d     = 1'b0;
                  state_d    = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         idx_q    <= '0;
         hold_q   <= '0;
         cnt_q    <= '0;
         prev_q   <= 1'b0;
         fd_reset <= 1'b1;
         fd_sel   <= 2'd0;
         gnt      <= '0;
         busy     <= 1'b0;
         tick     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         idx_q    <= idx_d;
         hold_q   <= hold_d;
         cnt_q    <= cnt_d;
         prev_q   <= prev_d;
         fd_reset <= fd_reset_d;
         fd_sel   <= fd_sel_d;
         gnt      <= gnt_d;
         busy     <= busy_d;
         tick     <= tick_d;
         done     <= done_d;
      end
   end

endmodule

// File: tb/tb_fd_rate_arbiter.sv
// Bench for fd_rate_arbiter with a behavioural model of the divider.
// Directed vector table plus hand sequences for abort, reset, round robin.
module tb_fd_rate_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  req;
   logic [7:0]  req_sel;
   logic [7:0]  hold_periods;
   logic        clk_after;
   logic        fd_reset;
   logic [1:0]  fd_sel;
   logic [3:0]  gnt;
   logic        busy;
   logic        tick;
   logic        done;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int last_done;

   fd_rate_arbiter #(.NREQ(4), .HOLD_W(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .req_sel      (req_sel),
      .hold_periods (hold_periods),
      .clk_after    (clk_after),
      .fd_reset     (fd_reset),
      .fd_sel       (fd_sel),
      .gnt          (gnt),
      .busy         (busy),
      .tick         (tick),
      .done         (done)
   );

   // Divider: free-running count held at 0 by reset_fd.
   logic [12:0] dcnt;
   logic [3:0]  bsel;
   always @(posedge clk) begin
      if (fd_reset) dcnt <= '0;
      else dcnt <= dcnt + 1'b1;
   end
   assign bsel = 4'd9 + {2'b00, fd_sel};
   assign clk_after = dcnt[bsel];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [3:0] req;
      logic [7:0] req_sel;
      logic [7:0] hold;
      logic [3:0] gnt;
      logic [1:0] sel;
      int         tick1;
      int         tickl;
      int         done_e;
      int         nticks;
   } vec_t;

   vec_t vecs[5];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic chk_rst(input string nm);
      chk({nm, "_fd_reset"}, 32'(fd_reset), 1);
      chk({nm, "_fd_sel"}, 32'(fd_sel), 0);
      chk({nm, "_gnt"}, 32'(gnt), 0);
      chk({nm, "_busy"}, 32'(busy), 0);
      chk({nm, "_tick"}, 32'(tick), 0);
      chk({nm, "_done"}, 32'(done), 0);
   endtask

   task automatic observe(input int base, input int max_e, output int nt,
                          output int t1, output int tl, output int de);
      nt = 0;
      t1 = -1;
      tl = -1;
      de = -1;
      while (cyc - base < max_e) begin
         step();
         if (tick) begin
            nt++;
            if (t1 < 0) t1 = cyc - base;
            tl = cyc - base;
         end
         if (done) begin
            de = cyc - base;
            break;
         end
      end
   endtask

   task automatic do_grant(input logic [3:0] exp, input string nm);
      int g_at;
      int d_at;
      g_at = -1;
      d_at = -1;
      for (int i = 0; i < 8; i++) begin
         step();
         if (gnt != 4'b0000) begin
            g_at = cyc;
            break;
         end
      end
      chk({nm, "_gnt"}, 32'(gnt), 32'(exp));
      if (last_done >= 0) chk({nm, "_gap"}, g_at - last_done, 1);
      for (int i = 0; i < 600; i++) begin
         step();
         if (done) begin
            d_at = cyc;
            break;
         end
      end
      chk({nm, "_done_lat"}, d_at - g_at, 514);
      last_done = d_at;
   endtask

   initial begin
      int base, nt, t1, tl, de, rise, nd;
      int tk[3];
      logic any_done, prev_ca;

      vecs[0] = '{4'b0001, 8'hFC, 8'd1, 4'b0001, 2'd0, 514, 514, 514, 1};
      vecs[1] = '{4'b0100, 8'h75, 8'd1, 4'b0100, 2'd3, 4098, 4098, 4098, 1};
      vecs[2] = '{4'b1000, 8'h6A, 8'd1, 4'b1000, 2'd1, 1026, 1026, 1026, 1};
      vecs[3] = '{4'b0010, 8'hF3, 8'd3, 4'b0010, 2'd0, 514, 2562, 2562, 3};
      vecs[4] = '{4'b0100, 8'h20, 8'd1, 4'b0100, 2'd2, 2050, 2050, 2050, 1};

      reset = 1'b1;
      req = '0;
      req_sel = '0;
      hold_periods = '0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_rst($sformatf("rst%0d", i));
      end
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_rst($sformatf("idle%0d", i));
      end

      // single grant, hold 2
      req = 4'b0001;
      req_sel = 8'h00;
      hold_periods = 8'd2;
      step();
      base = cyc;
      chk("sg_gnt", 32'(gnt), 1);
      chk("sg_busy", 32'(busy), 1);
      chk("sg_rst_e0", 32'(fd_reset), 1);
      step();
      chk("sg_rst_e1", 32'(fd_reset), 0);
      observe(base, 1600, nt, t1, tl, de);
      chk("sg_nticks", nt, 2);
      chk("sg_tick1", t1, 514);
      chk("sg_tick2", tl, 1538);
      chk("sg_done", de, 1538);
      chk("sg_gnt_off", 32'(gnt), 0);
      chk("sg_rst_on", 32'(fd_reset), 1);
      req = '0;
      step();
      chk("sg_idle_gnt", 32'(gnt), 0);

      // directed vectors; slices of the granted requester are
      // scrambled after the grant and must have no effect
      for (int v = 0; v < 5; v++) begin
         req = vecs[v].req;
         req_sel = vecs[v].req_sel;
         hold_periods = vecs[v].hold;
         step();
         base = cyc;
         chk($sformatf("v%0d_gnt", v), 32'(gnt), 32'(vecs[v].gnt));
         chk($sformatf("v%0d_sel", v), 32'(fd_sel), 32'(vecs[v].sel));
         chk($sformatf("v%0d_busy", v), 32'(busy), 1);
         req_sel = ~req_sel;
         hold_periods = hold_periods + 8'd5;
         step();
         chk($sformatf("v%0d_rst_e1", v), 32'(fd_reset), 0);
         observe(base, vecs[v].done_e + 20, nt, t1, tl, de);
         chk($sformatf("v%0d_nticks", v), nt, vecs[v].nticks);
         chk($sformatf("v%0d_tick1", v), t1, vecs[v].tick1);
         chk($sformatf("v%0d_tickl", v), tl, vecs[v].tickl);
         chk($sformatf("v%0d_done", v), de, vecs[v].done_e);
         chk($sformatf("v%0d_sel_held", v), 32'(fd_sel), 32'(vecs[v].sel));
         chk($sformatf("v%0d_gnt_off", v), 32'(gnt), 0);
         req = '0;
         step();
         chk($sformatf("v%0d_idle", v), 32'(busy), 0);
      end

      // unlimited hold, then abort on the 4th rise
      req = 4'b0010;
      req_sel = 8'hF3;
      hold_periods = 8'd0;
      step();
      base = cyc;
      chk("ab_gnt", 32'(gnt), 2);
      nt = 0;
      any_done = 1'b0;
      tk[0] = 0;
      tk[1] = 0;
      tk[2] = 0;
      while (nt < 3 && cyc - base < 3000) begin
         step();
         if (done) any_done = 1'b1;
         if (tick) begin
            tk[nt] = cyc - base;
            nt++;
         end
      end
      chk("ab_nticks", nt, 3);
      chk("ab_tick1", tk[0], 514);
      chk("ab_space1", tk[1] - tk[0], 1024);
      chk("ab_space2", tk[2] - tk[1], 1024);
      prev_ca = clk_after;
      rise = -1;
      while (cyc - base < 4000) begin
         step();
         if (done) any_done = 1'b1;
         if (clk_after && !prev_ca) begin
            rise = cyc - base;
            break;
         end
         prev_ca = clk_after;
      end
      chk("ab_rise4", rise, 3585);
      req = '0;
      step();
      chk("ab_gnt_off", 32'(gnt), 0);
      chk("ab_tick", 32'(tick), 0);
      chk("ab_done", 32'(done), 0);
      chk("ab_fd_reset", 32'(fd_reset), 1);
      chk("ab_busy", 32'(busy), 0);
      chk("ab_never_done", 32'(any_done), 0);

      // reset during RUN after one tick
      req = 4'b0100;
      req_sel = 8'h10;
      hold_periods = 8'd0;
      step();
      base = cyc;
      chk("mr_sel", 32'(fd_sel), 1);
      nd = 0;
      while (!tick && cyc - base < 1200) step();
      chk("mr_tick1", cyc - base, 1026);
      reset = 1'b1;
      step();
      chk_rst("mr");
      req = 4'b1111;
      req_sel = 8'h00;
      hold_periods = 8'd1;
      step();
      chk("mr_held_gnt", 32'(gnt), 0);
      reset = 1'b0;
      last_done = -1;

      // round robin, all requesting
      do_grant(4'b0001, "rr0");
      do_grant(4'b0010, "rr1");
      do_grant(4'b0100, "rr2");
      do_grant(4'b1000, "rr3");
      do_grant(4'b0001, "rr4");
      req = '0;
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      req = 4'b0101;
      last_done = -1;
      do_grant(4'b0001, "rs0");
      do_grant(4'b0100, "rs1");
      do_grant(4'b0001, "rs2");
      do_grant(4'b0100, "rs3");
      req = '0;
      step();
      chk("end_idle", 32'(gnt), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
